// File: rtl/otp_cipher_unit.sv
// One-time-pad cipher front end: debounced load press -> uniform key from LFSR -> enc/dec mod ALPHABET.
// Latency 4 cycles from debounced press to enable; no backpressure, presses while busy are dropped.
module otp_cipher_unit #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1,
  parameter int unsigned ALPHABET        = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_btn,
  input  logic [4:0] switch_val_in,
  output logic [4:0] encrypted_text,
  output logic [4:0] decrypted_text,
  output logic       enable,
  output logic [4:0] key_out,
  output logic       busy,
  output logic       invalid
);

  localparam int unsigned CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [5:0]  MOD      = 6'(ALPHABET);
  localparam logic [4:0]  MAX_CODE = 5'(ALPHABET - 1);
  localparam logic [4:0]  DASH     = 5'(ALPHABET);
  localparam logic [15:0] SEED     = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEYGEN,
    S_ENCRYPT,
    S_DECRYPT,
    S_STROBE
  } state_t;

  logic [1:0]    r_sync;
  logic          r_deb;
  logic [CW-1:0] r_cnt;
  logic          r_press;
  logic [15:0]   r_lfsr;
  logic          w_fb;
  state_t        r_state;
  logic [4:0]    r_plain;
  logic [4:0]    r_key;
  logic [4:0]    r_enc;
  logic [5:0]    w_sum;
  logic [4:0]    w_enc;
  logic [4:0]    w_dec;
  logic [4:0]    r_enc_out;
  logic [4:0]    r_dec_out;
  logic [4:0]    r_key_out;
  logic          r_enable;
  logic          r_invalid;
  logic          r_busy;

  // Press pulse is registered alongside the 0->1 flip of the debounced level.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync  <= 2'b00;
      r_deb   <= 1'b0;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], load_btn};
      r_press <= 1'b0;
      if (r_sync[1] != r_deb) begin
        if (r_cnt == CNT_MAX) begin
          r_deb   <= r_sync[1];
          r_cnt   <= '0;
          r_press <= r_sync[1];
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign w_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= {w_fb, r_lfsr[15:1]};
    end
  end

  assign w_sum = {1'b0, r_plain} + {1'b0, r_key};
  assign w_enc = (w_sum >= MOD) ? 5'(w_sum - MOD) : 5'(w_sum);
  assign w_dec = (r_enc >= r_key) ? 5'({1'b0, r_enc} - {1'b0, r_key})
                                  : 5'({1'b0, r_enc} + MOD - {1'b0, r_key});

  // Outputs load on the DECRYPT->STROBE edge so the pair is valid during the enable cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_plain   <= 5'd0;
      r_key     <= 5'd0;
      r_enc     <= 5'd0;
      r_enc_out <= DASH;
      r_dec_out <= DASH;
      r_key_out <= 5'd0;
      r_enable  <= 1'b0;
      r_invalid <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_enable  <= 1'b0;
      r_invalid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_press) begin
            if (switch_val_in <= MAX_CODE) begin
              r_plain <= switch_val_in;
              r_busy  <= 1'b1;
              r_state <= S_KEYGEN;
            end else begin
              r_invalid <= 1'b1;
            end
          end
        end
        S_KEYGEN: begin
          if (r_lfsr[4:0] <= MAX_CODE) begin
            r_key   <= r_lfsr[4:0];
            r_state <= S_ENCRYPT;
          end
        end
        S_ENCRYPT: begin
          r_enc   <= w_enc;
          r_state <= S_DECRYPT;
        end
        S_DECRYPT: begin
          r_enc_out <= r_enc;
          r_dec_out <= w_dec;
          r_key_out <= r_key;
          r_enable  <= 1'b1;
          r_state   <= S_STROBE;
        end
        S_STROBE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign encrypted_text = r_enc_out;
  assign decrypted_text = r_dec_out;
  assign key_out        = r_key_out;
  assign enable         = r_enable;
  assign invalid        = r_invalid;
  assign busy           = r_busy;

endmodule
